serial_rx: RTL and testbench
============================

SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 Parameter: DEPTH, 4, receive FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 nRst  input  1  asynchronous, active-low reset.
REQ-004 rx  input  1  serial line from the byte serialiser; idles high.
REQ-005 ready  input  1  consumer accepts head byte this cycle when valid is high.
REQ-006 data  output  8  FIFO head byte; meaningful only while valid is high.
REQ-007 valid  output  1  FIFO not empty.
REQ-008 level  output  5  current FIFO occupancy, 0..DEPTH.
REQ-009 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 overflow  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-011 Frame format: start bit 0, 8 data bits LSB first, stop bit 1, one bit per clk cycle, no oversampling.
REQ-012 Frame FSM states: IDLE, DATA, STOP, BREAK.
REQ-013 IDLE: rx==0 sampled -> DATA with bit counter cleared; rx==1 -> stay.
REQ-014 DATA: each cycle shift rx into bit position = counter; after the 8th bit -> STOP.
REQ-015 STOP with rx==1: frame good; byte offered to the FIFO that edge; -> IDLE.
REQ-016 Back-to-back frames: a start bit in the cycle immediately after the stop bit is accepted with no gap.
REQ-017 STOP with rx==0: frame_err pulses the next cycle; byte discarded; -> BREAK.
REQ-018 BREAK: stay while rx==0; rx==1 -> IDLE; a 0 in BREAK is never taken as a start bit.
REQ-019 Push latency: valid rises on the cycle after the stop-bit edge; no same-cycle bypass.
REQ-020 Pop: valid && ready removes the head at that edge; the next entry appears on data the following cycle.
REQ-021 Push when level==DEPTH and no pop that edge: byte dropped; overflow pulses the next cycle; FIFO contents unchanged.
REQ-022 Push and pop on the same edge when full: both take effect; level stays DEPTH; no overflow.
REQ-023 Push and pop on the same edge at any other level: level unchanged.
REQ-024 ready while valid is low has no effect; level never underflows.
REQ-025 Read/write pointers wrap modulo DEPTH; level is tracked by counter, not by pointer compare alone.
REQ-026 frame_err and overflow never assert in the same cycle, since only one frame completes per cycle.

Reset
REQ-027 nRst low: FSM -> IDLE, counter 0, pointers 0, level 0, valid 0, data 0, frame_err 0, overflow 0, immediately and asynchronously.
REQ-028 Reset mid-frame: the partial byte is lost; after release a frame is recognised only from a fresh start bit.
REQ-029 FIFO storage contents need not be reset; data reads 0 whenever level==0.

Verification
REQ-030 Reset, rx idle high, send 0xA5 frame -> valid rises 1 cycle after stop bit, data=0xA5, level=1, no pulses.
REQ-031 Three back-to-back frames 0x01,0x80,0xFF with ready=0, then ready=1 -> popped in order 0x01,0x80,0xFF, level 3->0.
REQ-032 DEPTH=4, ready=0, send 5 good frames -> level=4, overflow pulses once after the 5th stop bit, head still the 1st byte.
REQ-033 Level 4 with ready=1 held, send 6th frame -> push and pop on the same edge, level stays 4, no overflow.
REQ-034 Frame 0x3C with stop bit 0, rx held 0 for 3 more cycles, then a good 0x55 -> frame_err single pulse, no push, only 0x55 received.
REQ-035 nRst asserted at data bit 4 of a frame, released, send 0x99 -> all outputs 0 during reset, then only 0x99 received.

Source files
------------

// File: rtl/serial_rx.sv
// Serial byte receiver: one bit per clock (start 0, 8 data bits LSB first,
// stop 1), with a DEPTH-entry receive FIFO behind a valid/ready pop port.
//
// Ports:
//   clk        single clock, all logic on its rising edge
//   nRst       asynchronous active-low reset
//   rx         serial line, idles high
//   ready      consumer takes the head byte when valid is high
//   data       FIFO head byte (0 while the FIFO is empty)
//   valid      FIFO not empty
//   level      FIFO occupancy, 0..DEPTH
//   frame_err  one-cycle pulse after a bad stop bit
//   overflow   one-cycle pulse after a good byte was dropped on a full FIFO
module serial_rx #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rx,
    input  logic       ready,
    output logic [7:0] data,
    output logic       valid,
    output logic [4:0] level,
    output logic       frame_err,
    output logic       overflow
);

    localparam int         AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL = 5'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t          r_state;
    logic [2:0]      r_cnt;
    logic [7:0]      r_shift;
    logic            r_frame_err;
    logic            r_overflow;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [4:0]      r_level;

    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_wr;

    // A good stop bit offers the assembled byte on the same edge.
    assign w_push = (r_state == STOP) && rx;
    assign w_pop  = (r_level != 5'd0) && ready;
    assign w_full = (r_level == FULL);
    // A full FIFO still accepts the byte when the head leaves on that edge.
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_shift     <= 8'd0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (!rx) begin
                        r_cnt   <= 3'd0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    r_shift[r_cnt] <= rx;
                    r_cnt          <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7)
                        r_state <= STOP;
                end
                STOP: begin
                    if (rx) begin
                        r_state <= IDLE;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= BREAK;
                    end
                end
                BREAK: begin
                    // A held-low line is a break, not a new start bit.
                    if (rx)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= 5'd0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push && w_full && !w_pop;
            if (w_wr)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_wr && !w_pop)
                r_level <= r_level + 5'd1;
            else if (!w_wr && w_pop)
                r_level <= r_level - 5'd1;
        end
    end

    // Storage is left unreset; the output mux hides stale entries.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= r_shift;
    end

    assign data      = (r_level == 5'd0) ? 8'd0 : r_mem[r_rptr];
    assign valid     = (r_level != 5'd0);
    assign level     = r_level;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_rx.sv
// Directed self-checking bench for serial_rx (DEPTH = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_rx;

    logic       clk;
    logic       nRst;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic [4:0] level;
    logic       frame_err;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    serial_rx #(.DEPTH(4)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .rx        (rx),
        .ready     (ready),
        .data      (data),
        .valid     (valid),
        .level     (level),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one frame; returns just after the stop bit is applied,
    // before the edge that samples it.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk) rx = 1'b0;
        for (int i = 0; i < 8; i++)
            @(negedge clk) rx = b[i];
        @(negedge clk) rx = stop;
    endtask

    logic [7:0] exp_q [4];

    initial begin
        nRst  = 1'b0;
        rx    = 1'b1;
        ready = 1'b0;
        #2;
        chk("rst_level", 8'(level), 8'd0);
        chk("rst_valid", 8'(valid), 8'd0);
        chk("rst_data", data, 8'd0);
        chk("rst_ferr", 8'(frame_err), 8'd0);
        chk("rst_ovf", 8'(overflow), 8'd0);
        @(negedge clk) nRst = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame, push latency
        send_frame(8'hA5, 1'b1);
        chk("a5_pre_valid", 8'(valid), 8'd0);
        @(negedge clk) rx = 1'b1;
        chk("a5_valid", 8'(valid), 8'd1);
        chk("a5_data", data, 8'hA5);
        chk("a5_level", 8'(level), 8'd1);
        chk("a5_ferr", 8'(frame_err), 8'd0);
        chk("a5_ovf", 8'(overflow), 8'd0);
        ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        chk("a5_pop_level", 8'(level), 8'd0);

        // Back-to-back frames, then in-order drain
        send_frame(8'h01, 1'b1);
        send_frame(8'h80, 1'b1);
        send_frame(8'hFF, 1'b1);
        @(negedge clk) rx = 1'b1;
        chk("b2b_level3", 8'(level), 8'd3);
        chk("b2b_data0", data, 8'h01);
        ready = 1'b1;
        @(negedge clk);
        chk("b2b_data1", data, 8'h80);
        chk("b2b_level2", 8'(level), 8'd2);
        @(negedge clk);
        chk("b2b_data2", data, 8'hFF);
        chk("b2b_level1", 8'(level), 8'd1);
        @(negedge clk);
        chk("b2b_level0", 8'(level), 8'd0);
        chk("b2b_valid0", 8'(valid), 8'd0);
        chk("b2b_data_empty", data, 8'd0);
        @(negedge clk);
        chk("underflow_level", 8'(level), 8'd0);
        ready = 1'b0;

        // Overflow on the fifth frame
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        send_frame(8'h55, 1'b1);
        @(negedge clk) rx = 1'b1;
        chk("ovf_pulse", 8'(overflow), 8'd1);
        chk("ovf_level", 8'(level), 8'd4);
        chk("ovf_head", data, 8'h11);
        chk("ovf_ferr", 8'(frame_err), 8'd0);
        @(negedge clk);
        chk("ovf_single", 8'(overflow), 8'd0);

        // Push and pop on the same edge while full
        send_frame(8'h66, 1'b1);
        ready = 1'b1;
        @(negedge clk) rx = 1'b1;
        chk("full_pp_level", 8'(level), 8'd4);
        chk("full_pp_ovf", 8'(overflow), 8'd0);
        exp_q[0] = 8'h22;
        exp_q[1] = 8'h33;
        exp_q[2] = 8'h44;
        exp_q[3] = 8'h66;
        chk("drain0", data, exp_q[0]);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("drain%0d", i), data, exp_q[i]);
        end
        @(negedge clk);
        chk("drain_level0", 8'(level), 8'd0);
        ready = 1'b0;

        // Bad stop bit, held break, then a good frame
        send_frame(8'h3C, 1'b0);
        @(negedge clk) rx = 1'b0;
        chk("ferr_pulse", 8'(frame_err), 8'd1);
        chk("ferr_nopush", 8'(valid), 8'd0);
        chk("ferr_ovf", 8'(overflow), 8'd0);
        @(negedge clk) rx = 1'b0;
        chk("ferr_single", 8'(frame_err), 8'd0);
        @(negedge clk) rx = 1'b0;
        @(negedge clk) rx = 1'b1;
        chk("brk_level", 8'(level), 8'd0);
        send_frame(8'h55, 1'b1);
        @(negedge clk) rx = 1'b1;
        chk("brk_good_level", 8'(level), 8'd1);
        chk("brk_good_data", data, 8'h55);
        chk("brk_good_ferr", 8'(frame_err), 8'd0);
        ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        chk("brk_pop_level", 8'(level), 8'd0);

        // Reset in the middle of a frame with a byte queued
        send_frame(8'h5A, 1'b1);
        @(negedge clk) rx = 1'b1;
        chk("pre_rst_level", 8'(level), 8'd1);
        @(negedge clk) rx = 1'b0;
        @(negedge clk) rx = 1'b0;
        @(negedge clk) rx = 1'b0;
        @(negedge clk) rx = 1'b1;
        @(negedge clk) rx = 1'b1;
        @(negedge clk) nRst = 1'b0;
        rx = 1'b1;
        #1;
        chk("mid_rst_level", 8'(level), 8'd0);
        chk("mid_rst_valid", 8'(valid), 8'd0);
        chk("mid_rst_data", data, 8'd0);
        chk("mid_rst_ferr", 8'(frame_err), 8'd0);
        chk("mid_rst_ovf", 8'(overflow), 8'd0);
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_level", 8'(level), 8'd0);
        send_frame(8'h99, 1'b1);
        @(negedge clk) rx = 1'b1;
        chk("post_rst_valid", 8'(valid), 8'd1);
        chk("post_rst_data", data, 8'h99);
        chk("post_rst_cnt", 8'(level), 8'd1);
        ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        chk("post_rst_pop", 8'(level), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
